// File: rtl/wb_fetch_pkg.sv
// Shared types for the Wishbone instruction-fetch master: FSM state encoding,
// the buffered parcel record and bus constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] instr;
    } parcel_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    function automatic logic [31:0] word_base(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_fetch_fifo.sv
// parcel_fifo: circular buffer of parcel_t accepting up to two writes and one
// read per cycle, with a flush that wins over any concurrent push or pop.
module parcel_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr0_en,
    input  parcel_t          wr0_data,
    input  logic             wr1_en,
    input  parcel_t          wr1_data,
    input  logic             rd_en,
    output parcel_t          rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free
);

    parcel_t          mem_q [DEPTH];
    parcel_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr1_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    // Pointer, count and storage update; the second write lands after the first.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = rd_en && (count_q != '0);
        wr1_ptr  = wr0_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            mem_d[wr_ptr_q] = wr0_en ? wr0_data : mem_q[wr_ptr_q];
            mem_d[wr1_ptr]  = wr1_en ? wr1_data : mem_d[wr1_ptr];
            wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Parcel storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;
    assign free     = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/wb_fetch.sv
// wb_fetch: Wishbone classic single-read instruction fetcher feeding a parcel FIFO.
// Define WB_FETCH_TIMEOUT_EN to add the ack watchdog and the sticky bus_err_o port.
module wb_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
`ifdef WB_FETCH_TIMEOUT_EN
    output logic        bus_err_o,
`endif
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [29:0] adr_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [15:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [29:0]      adr_q, adr_d;
    logic             stb_q, stb_d;
    logic             skip_lo_q, skip_lo_d;
    logic             discard_q, discard_d;
    logic             capture;
    logic             push_lo, push_hi;
    logic             issue_ok;
    logic             halt;
    logic             tmo_hit;
    logic [CNT_W-1:0] fifo_free;
    logic [CNT_W-1:0] fifo_count;
    parcel_t          lo_parcel, hi_parcel, head;

`ifdef WB_FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;

    // Watchdog: counts cycles spent in REQ; a redirect is the only way out of an error.
    always_comb begin
        tmo_cnt_d = (state_q == REQ) ? (tmo_cnt_q + TMO_W'(1)) : '0;
        if (redirect_i) begin
            bus_err_d = 1'b0;
        end else if (tmo_hit) begin
            bus_err_d = 1'b1;
        end else begin
            bus_err_d = bus_err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign tmo_hit   = (state_q == REQ) && !ack_i && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    assign halt      = bus_err_q;
    assign bus_err_o = bus_err_q;
`else
    assign tmo_hit = 1'b0;
    assign halt    = 1'b0;
`endif

    assign lo_parcel = '{pc: word_base(fetch_pc_q),          instr: dat_i[15:0]};
    assign hi_parcel = '{pc: word_base(fetch_pc_q) + 32'd2, instr: dat_i[31:16]};

    // Fetch FSM next state, PC tracking and push generation.
    always_comb begin
        state_d  = state_q;
        // A redirect flushes the FIFO, so the whole buffer is free for the next issue.
        issue_ok = redirect_i || (fifo_free >= CNT_W'(2));
        capture  = (state_q == REQ) && ack_i && !discard_q && !redirect_i;
        push_lo  = capture && !skip_lo_q;
        push_hi  = capture;

        case (state_q)
            IDLE: begin
                if (issue_ok && (redirect_i || !halt)) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack_i) begin
                    state_d = GAP;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            GAP: begin
                if (issue_ok) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:1], 1'b0};
            skip_lo_d  = redirect_pc_i[1];
        end else if (capture) begin
            fetch_pc_d = word_base(fetch_pc_q) + 32'd4;
            skip_lo_d  = 1'b0;
        end else begin
            fetch_pc_d = fetch_pc_q;
            skip_lo_d  = skip_lo_q;
        end

        // The in-flight read cannot be abandoned, so a redirect marks its data for discard.
        if ((state_q == REQ) && (ack_i || tmo_hit)) begin
            discard_d = 1'b0;
        end else if ((state_q == REQ) && redirect_i) begin
            discard_d = 1'b1;
        end else begin
            discard_d = discard_q;
        end

        if ((state_d == REQ) && (state_q != REQ)) begin
            adr_d = fetch_pc_d[31:2];
        end else begin
            adr_d = adr_q;
        end
        stb_d = (state_d == REQ);
    end

    // FSM and bus registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            adr_q      <= RESET_PC[31:2];
            stb_q      <= 1'b0;
            skip_lo_q  <= RESET_PC[1];
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            adr_q      <= adr_d;
            stb_q      <= stb_d;
            skip_lo_q  <= skip_lo_d;
            discard_q  <= discard_d;
        end
    end

    parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .flush    (redirect_i),
        .wr0_en   (push_lo),
        .wr0_data (lo_parcel),
        .wr1_en   (push_hi),
        .wr1_data (hi_parcel),
        .rd_en    (instr_ready_i),
        .rd_data  (head),
        .rd_valid (instr_valid_o),
        .count    (fifo_count),
        .free     (fifo_free)
    );

    assign cyc_o      = stb_q;
    assign stb_o      = stb_q;
    assign we_o       = 1'b0;
    assign sel_o      = WB_SEL_ALL;
    assign adr_o      = adr_q;
    assign instr_o    = head.instr;
    assign instr_pc_o = head.pc;

endmodule

// File: tb/tb_wb_fetch.sv
// Directed self-checking bench for wb_fetch with a registered-ack Wishbone slave.
module tb_wb_fetch;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [29:0] adr_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [15:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        ack_en;
`ifdef WB_FETCH_TIMEOUT_EN
    logic        bus_err_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n_stb    = 0;

    always #5 clk = ~clk;

    wb_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0104), .TIMEOUT(16)) dut (
        .sys_clk       (clk),
        .sys_rst       (sys_rst),
`ifdef WB_FETCH_TIMEOUT_EN
        .bus_err_o     (bus_err_o),
`endif
        .cyc_o         (cyc_o),
        .stb_o         (stb_o),
        .we_o          (we_o),
        .sel_o         (sel_o),
        .adr_o         (adr_o),
        .dat_i         (dat_i),
        .ack_i         (ack_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'h41:  return 32'h3118_63C6;
            30'h42:  return 32'hBEEF_CAFE;
            30'h43:  return 32'h1357_2468;
            30'h50:  return 32'h5A2B_748E;
            default: return {16'hDEAD, a[15:0]};
        endcase
    endfunction

    // Slave: ack follows stb by one cycle and stays high while stb stays high.
    always @(posedge clk) begin
        if (sys_rst) begin
            ack_i <= 1'b0;
        end else begin
            ack_i <= cyc_o && stb_o && ack_en;
        end
        dat_i <= mem_word(adr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with reset low).
    task automatic do_reset(input logic ready);
        sys_rst       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = ready;
        ack_en        = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        // Reset state and startup sequence
        do_reset(1'b1);
        check("rst_cyc", {31'd0, cyc_o}, 32'd0);
        check("rst_stb", {31'd0, stb_o}, 32'd0);
        check("rst_adr", {2'b00, adr_o}, 32'h41);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("we_tied", {31'd0, we_o}, 32'd0);
        check("sel_tied", {28'd0, sel_o}, 32'hF);
`ifdef WB_FETCH_TIMEOUT_EN
        check("rst_err", {31'd0, bus_err_o}, 32'd0);
`endif
        tick();  // c1
        check("c1_stb", {31'd0, stb_o}, 32'd1);
        check("c1_adr", {2'b00, adr_o}, 32'h41);
        tick();  // c2
        check("c2_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();  // c3
        check("c3_valid", {31'd0, instr_valid_o}, 32'd1);
        check("c3_instr", {16'd0, instr_o}, 32'h63C6);
        check("c3_pc", instr_pc_o, 32'h104);
        check("c3_gap", {31'd0, stb_o}, 32'd0);
        tick();  // c4
        check("c4_stb", {31'd0, stb_o}, 32'd1);
        check("c4_adr", {2'b00, adr_o}, 32'h42);
        check("c4_instr", {16'd0, instr_o}, 32'h3118);
        check("c4_pc", instr_pc_o, 32'h106);
        tick();  // c5
        check("c5_empty", {31'd0, instr_valid_o}, 32'd0);
        tick();  // c6
        check("c6_instr", {16'd0, instr_o}, 32'hCAFE);
        check("c6_pc", instr_pc_o, 32'h108);

        // Redirect to an odd halfword skips the low parcel
        do_reset(1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h106;
        tick();  // c1
        redirect_i = 1'b0;
        check("rd106_c1_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rd106_c1_stb", {31'd0, stb_o}, 32'd1);
        tick();
        tick();  // c3
        check("rd106_instr", {16'd0, instr_o}, 32'h3118);
        check("rd106_pc", instr_pc_o, 32'h106);
        tick();  // c4
        check("rd106_no_lo", {31'd0, instr_valid_o}, 32'd0);
        check("rd106_next_adr", {2'b00, adr_o}, 32'h42);

        // Backpressure: two fetches fill DEPTH=4, then stall
        do_reset(1'b0);
        n_stb = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (stb_o) n_stb++;
        end
        check("bp_stb_cycles", n_stb, 32'd4);
        check("bp_idle_stb", {31'd0, stb_o}, 32'd0);
        check("bp_head", {16'd0, instr_o}, 32'h63C6);
        instr_ready_i = 1'b1;
        tick();  // c15
        check("bp_c15_instr", {16'd0, instr_o}, 32'h3118);
        tick();  // c16
        check("bp_c16_instr", {16'd0, instr_o}, 32'hCAFE);
        check("bp_c16_stb", {31'd0, stb_o}, 32'd0);
        tick();  // c17
        check("bp_resume_stb", {31'd0, stb_o}, 32'd1);
        check("bp_resume_adr", {2'b00, adr_o}, 32'h43);
        check("bp_c17_pc", instr_pc_o, 32'h10A);

        // Redirect while REQ for 0x104 is in flight
        do_reset(1'b1);
        tick();  // c1
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h140;
        tick();  // c2
        redirect_i = 1'b0;
        check("rq_hold_stb", {31'd0, stb_o}, 32'd1);
        check("rq_hold_adr", {2'b00, adr_o}, 32'h41);
        tick();  // c3
        check("rq_c3_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();  // c4
        check("rq_c4_adr", {2'b00, adr_o}, 32'h50);
        tick();  // c5
        check("rq_c5_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();  // c6
        check("rq_instr", {16'd0, instr_o}, 32'h748E);
        check("rq_pc", instr_pc_o, 32'h140);

        // A second redirect while the discard is pending wins
        do_reset(1'b1);
        ack_en = 1'b0;
        tick();  // c1
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h140;
        tick();  // c2
        redirect_pc_i = 32'h108;
        tick();  // c3
        redirect_i = 1'b0;
        ack_en     = 1'b1;
        check("rr_hold_adr", {2'b00, adr_o}, 32'h41);
        tick();
        tick();  // c5
        check("rr_gap_stb", {31'd0, stb_o}, 32'd0);
        tick();  // c6
        check("rr_adr", {2'b00, adr_o}, 32'h42);
        tick();
        tick();  // c8
        check("rr_instr", {16'd0, instr_o}, 32'hCAFE);
        check("rr_pc", instr_pc_o, 32'h108);

        // Redirect and pop in the same cycle
        do_reset(1'b1);
        tick();
        tick();
        tick();  // c3, head valid and ready high
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h108;
        tick();  // c4
        redirect_i = 1'b0;
        check("rp_empty", {31'd0, instr_valid_o}, 32'd0);
        check("rp_stb", {31'd0, stb_o}, 32'd1);
        check("rp_adr", {2'b00, adr_o}, 32'h42);
        tick();
        tick();  // c6
        check("rp_instr", {16'd0, instr_o}, 32'hCAFE);
        tick();  // c7
        check("rp_instr2", {16'd0, instr_o}, 32'hBEEF);
        check("rp_pc2", instr_pc_o, 32'h10A);

        // Reset asserted during REQ drops the strobe
        do_reset(1'b1);
        tick();  // c1
        sys_rst = 1'b1;
        tick();
        check("rst_req_drop", {31'd0, stb_o}, 32'd0);
        sys_rst = 1'b0;

`ifdef WB_FETCH_TIMEOUT_EN
        // Ack watchdog
        do_reset(1'b1);
        ack_en = 1'b0;
        for (int i = 1; i <= 16; i++) tick();
        check("tmo_c16_stb", {31'd0, stb_o}, 32'd1);
        tick();  // c17
        check("tmo_c17_cyc", {31'd0, cyc_o}, 32'd0);
        check("tmo_err", {31'd0, bus_err_o}, 32'd1);
        tick();
        tick();
        tick();  // c20
        check("tmo_halt", {31'd0, stb_o}, 32'd0);
        ack_en        = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h104;
        tick();  // c21
        redirect_i = 1'b0;
        check("tmo_restart_stb", {31'd0, stb_o}, 32'd1);
        check("tmo_err_clr", {31'd0, bus_err_o}, 32'd0);
        tick();
        tick();  // c23
        check("tmo_instr", {16'd0, instr_o}, 32'h63C6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
